// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, combinational imem read, IF/ID register,
// stall/redirect handling and sticky fetch-fault detection.
module fetch_stage #(
  parameter int unsigned     N          = 64,
  parameter int unsigned     IMEM_WORDS = 64,
  parameter logic [N-1:0]    RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          stall_i,
  input  logic                          redirect_i,
  input  logic [N-1:0]                  redirect_pc_i,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr_o,
  input  logic [31:0]                   imem_rdata_i,
  output logic [N-1:0]                  fetch_pc_o,
  output logic [31:0]                   instr_d_o,
  output logic [N-1:0]                  pc_d_o,
  output logic                          valid_d_o,
  output logic                          fault_o,
  output logic [1:0]                    fault_cause_o
);

  localparam int unsigned AW       = $clog2(IMEM_WORDS);
  localparam logic [N-1:0] PC_LIMIT = N'(IMEM_WORDS) << 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_MISALIGN  = 2'b01,
    CAUSE_RANGE     = 2'b10
  } cause_t;

  state_t         state;
  logic [N-1:0]   pc;
  logic [31:0]    instr_d;
  logic [N-1:0]   pc_d;
  logic           valid_d;
  logic           fault;
  cause_t         fault_cause;
  logic           pc_out_of_range;

  assign pc_out_of_range = (pc >= PC_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr_d     <= '0;
      pc_d        <= '0;
      valid_d     <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end

        RUN: begin
          // Priority: misaligned redirect, redirect, stall, range fault, capture.
          if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            state       <= HALT;
            fault       <= 1'b1;
            fault_cause <= CAUSE_MISALIGN;
            instr_d     <= '0;
            pc_d        <= '0;
            valid_d     <= 1'b0;
          end else if (redirect_i) begin
            pc      <= redirect_pc_i;
            instr_d <= '0;
            pc_d    <= '0;
            valid_d <= 1'b0;
          end else if (stall_i) begin
            pc      <= pc;
          end else if (pc_out_of_range) begin
            state       <= HALT;
            fault       <= 1'b1;
            fault_cause <= CAUSE_RANGE;
            instr_d     <= '0;
            pc_d        <= '0;
            valid_d     <= 1'b0;
          end else begin
            instr_d <= imem_rdata_i;
            pc_d    <= pc;
            valid_d <= 1'b1;
            pc      <= pc + N'(4);
          end
        end

        HALT: begin
          valid_d <= 1'b0;
        end

        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  assign imem_addr_o   = pc[AW+1:2];
  assign fetch_pc_o    = pc;
  assign instr_d_o     = instr_d;
  assign pc_d_o        = pc_d;
  assign valid_d_o     = valid_d;
  assign fault_o       = fault;
  assign fault_cause_o = fault_cause;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, misaligned and range faults, async reset.
module tb_fetch_stage;

  localparam int unsigned N  = 64;
  localparam int unsigned IW = 64;
  localparam int unsigned AW = $clog2(IW);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall_i;
  logic          redirect_i;
  logic [N-1:0]  redirect_pc_i;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_rdata_i;
  logic [N-1:0]  fetch_pc_o;
  logic [31:0]   instr_d_o;
  logic [N-1:0]  pc_d_o;
  logic          valid_d_o;
  logic          fault_o;
  logic [1:0]    fault_cause_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // Instruction memory: word i holds F84000A0 + i.
  assign imem_rdata_i = 32'hF84000A0 + 32'(imem_addr_o);

  fetch_stage #(.N(64), .IMEM_WORDS(64), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .fetch_pc_o    (fetch_pc_o),
    .instr_d_o     (instr_d_o),
    .pc_d_o        (pc_d_o),
    .valid_d_o     (valid_d_o),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release mid-cycle, pass through BOOT and first capture edge untouched.
  task automatic reset_and_boot();
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    reset_n = 1'b0;
    #13;
    if (fetch_pc_o !== 64'h0) begin n_mis++; $display("FAIL reset_pc got %h exp %h", fetch_pc_o, 64'h0); end n_cmp++;
    if (instr_d_o !== 32'h0) begin n_mis++; $display("FAIL reset_instr got %h exp %h", instr_d_o, 32'h0); end n_cmp++;
    if (pc_d_o !== 64'h0) begin n_mis++; $display("FAIL reset_pc_d got %h exp %h", pc_d_o, 64'h0); end n_cmp++;
    if (valid_d_o !== 1'b0) begin n_mis++; $display("FAIL reset_valid got %b exp 0", valid_d_o); end n_cmp++;
    if (fault_o !== 1'b0) begin n_mis++; $display("FAIL reset_fault got %b exp 0", fault_o); end n_cmp++;
    if (fault_cause_o !== 2'b00) begin n_mis++; $display("FAIL reset_cause got %b exp 00", fault_cause_o); end n_cmp++;
    if (imem_addr_o !== 6'd0) begin n_mis++; $display("FAIL reset_imem_addr got %0d exp 0", imem_addr_o); end n_cmp++;
  endtask

  task automatic test_boot_fetch();
    step();
    reset_n = 1'b1;
    step();
    if (valid_d_o !== 1'b0) begin n_mis++; $display("FAIL boot_valid got %b exp 0", valid_d_o); end n_cmp++;
    if (fetch_pc_o !== 64'h0) begin n_mis++; $display("FAIL boot_pc got %h exp %h", fetch_pc_o, 64'h0); end n_cmp++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (instr_d_o !== 32'hF84000A0 + 32'(i)) begin n_mis++; $display("FAIL seq_instr%0d got %h exp %h", i, instr_d_o, 32'hF84000A0 + 32'(i)); end n_cmp++;
      if (pc_d_o !== 64'(4 * i)) begin n_mis++; $display("FAIL seq_pc_d%0d got %h exp %h", i, pc_d_o, 64'(4 * i)); end n_cmp++;
      if (valid_d_o !== 1'b1) begin n_mis++; $display("FAIL seq_valid%0d got %b exp 1", i, valid_d_o); end n_cmp++;
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (instr_d_o !== 32'hF84000A2) begin n_mis++; $display("FAIL stall_instr%0d got %h exp %h", i, instr_d_o, 32'hF84000A2); end n_cmp++;
      if (pc_d_o !== 64'h8) begin n_mis++; $display("FAIL stall_pc_d%0d got %h exp %h", i, pc_d_o, 64'h8); end n_cmp++;
      if (fetch_pc_o !== 64'hC) begin n_mis++; $display("FAIL stall_fetch_pc%0d got %h exp %h", i, fetch_pc_o, 64'hC); end n_cmp++;
      if (valid_d_o !== 1'b1) begin n_mis++; $display("FAIL stall_valid%0d got %b exp 1", i, valid_d_o); end n_cmp++;
    end
    stall_i = 1'b0;
    step();
    if (instr_d_o !== 32'hF84000A3) begin n_mis++; $display("FAIL post_stall_instr got %h exp %h", instr_d_o, 32'hF84000A3); end n_cmp++;
    if (pc_d_o !== 64'hC) begin n_mis++; $display("FAIL post_stall_pc_d got %h exp %h", pc_d_o, 64'hC); end n_cmp++;
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 64'h40; stall_i = 1'b1;
    step();
    redirect_i = 1'b0; stall_i = 1'b0; redirect_pc_i = '0;
    if (fetch_pc_o !== 64'h40) begin n_mis++; $display("FAIL redir_fetch_pc got %h exp %h", fetch_pc_o, 64'h40); end n_cmp++;
    if (valid_d_o !== 1'b0) begin n_mis++; $display("FAIL redir_bubble got %b exp 0", valid_d_o); end n_cmp++;
    step();
    if (instr_d_o !== 32'hF84000B0) begin n_mis++; $display("FAIL redir_instr got %h exp %h", instr_d_o, 32'hF84000B0); end n_cmp++;
    if (pc_d_o !== 64'h40) begin n_mis++; $display("FAIL redir_pc_d got %h exp %h", pc_d_o, 64'h40); end n_cmp++;
    if (valid_d_o !== 1'b1) begin n_mis++; $display("FAIL redir_valid got %b exp 1", valid_d_o); end n_cmp++;
    if (fetch_pc_o !== 64'h44) begin n_mis++; $display("FAIL redir_next_pc got %h exp %h", fetch_pc_o, 64'h44); end n_cmp++;
  endtask

  task automatic test_misaligned();
    redirect_i = 1'b1; redirect_pc_i = 64'h42;
    step();
    redirect_i = 1'b0; redirect_pc_i = '0;
    if (fault_o !== 1'b1) begin n_mis++; $display("FAIL mis_fault got %b exp 1", fault_o); end n_cmp++;
    if (fault_cause_o !== 2'b01) begin n_mis++; $display("FAIL mis_cause got %b exp 01", fault_cause_o); end n_cmp++;
    if (valid_d_o !== 1'b0) begin n_mis++; $display("FAIL mis_valid got %b exp 0", valid_d_o); end n_cmp++;
    if (instr_d_o !== 32'h0) begin n_mis++; $display("FAIL mis_flush_instr got %h exp 0", instr_d_o); end n_cmp++;
    if (pc_d_o !== 64'h0) begin n_mis++; $display("FAIL mis_flush_pc_d got %h exp 0", pc_d_o); end n_cmp++;
    for (int i = 0; i < 10; i++) begin
      stall_i = i[0];
      redirect_i = i[1];
      redirect_pc_i = 64'h80 + 64'(4 * i);
      step();
      if (fetch_pc_o !== 64'h44) begin n_mis++; $display("FAIL halt_pc%0d got %h exp %h", i, fetch_pc_o, 64'h44); end n_cmp++;
      if (valid_d_o !== 1'b0) begin n_mis++; $display("FAIL halt_valid%0d got %b exp 0", i, valid_d_o); end n_cmp++;
      if (fault_cause_o !== 2'b01) begin n_mis++; $display("FAIL halt_cause%0d got %b exp 01", i, fault_cause_o); end n_cmp++;
    end
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
  endtask

  task automatic test_range();
    reset_and_boot();
    if (fault_o !== 1'b0) begin n_mis++; $display("FAIL rst_clears_fault got %b exp 0", fault_o); end n_cmp++;
    redirect_i = 1'b1; redirect_pc_i = 64'hF8;
    step();
    redirect_i = 1'b0; redirect_pc_i = '0;
    if (fetch_pc_o !== 64'hF8) begin n_mis++; $display("FAIL range_redir_pc got %h exp %h", fetch_pc_o, 64'hF8); end n_cmp++;
    for (int i = 0; i < 2; i++) begin
      step();
      if (pc_d_o !== 64'hF8 + 64'(4 * i)) begin n_mis++; $display("FAIL range_pc_d%0d got %h exp %h", i, pc_d_o, 64'hF8 + 64'(4 * i)); end n_cmp++;
      if (instr_d_o !== 32'hF84000DE + 32'(i)) begin n_mis++; $display("FAIL range_instr%0d got %h exp %h", i, instr_d_o, 32'hF84000DE + 32'(i)); end n_cmp++;
      if (valid_d_o !== 1'b1) begin n_mis++; $display("FAIL range_valid%0d got %b exp 1", i, valid_d_o); end n_cmp++;
      if (fault_o !== 1'b0) begin n_mis++; $display("FAIL range_early_fault%0d got %b exp 0", i, fault_o); end n_cmp++;
    end
    step();
    if (fault_o !== 1'b1) begin n_mis++; $display("FAIL range_fault got %b exp 1", fault_o); end n_cmp++;
    if (fault_cause_o !== 2'b10) begin n_mis++; $display("FAIL range_cause got %b exp 10", fault_cause_o); end n_cmp++;
    if (valid_d_o !== 1'b0) begin n_mis++; $display("FAIL range_valid_end got %b exp 0", valid_d_o); end n_cmp++;
    if (fetch_pc_o !== 64'h100) begin n_mis++; $display("FAIL range_pc_hold got %h exp %h", fetch_pc_o, 64'h100); end n_cmp++;
    if (pc_d_o !== 64'h0) begin n_mis++; $display("FAIL range_flush_pc_d got %h exp 0", pc_d_o); end n_cmp++;
  endtask

  task automatic test_async_reset();
    reset_and_boot();
    step();
    step();
    if (valid_d_o !== 1'b1) begin n_mis++; $display("FAIL ar_pre_valid got %b exp 1", valid_d_o); end n_cmp++;
    #2;
    reset_n = 1'b0;
    #1;
    if (valid_d_o !== 1'b0) begin n_mis++; $display("FAIL ar_valid got %b exp 0", valid_d_o); end n_cmp++;
    if (instr_d_o !== 32'h0) begin n_mis++; $display("FAIL ar_instr got %h exp 0", instr_d_o); end n_cmp++;
    if (pc_d_o !== 64'h0) begin n_mis++; $display("FAIL ar_pc_d got %h exp 0", pc_d_o); end n_cmp++;
    if (fetch_pc_o !== 64'h0) begin n_mis++; $display("FAIL ar_fetch_pc got %h exp 0", fetch_pc_o); end n_cmp++;
    step();
    reset_n = 1'b1;
    step();
    if (valid_d_o !== 1'b0) begin n_mis++; $display("FAIL ar_boot_valid got %b exp 0", valid_d_o); end n_cmp++;
    step();
    if (instr_d_o !== 32'hF84000A0) begin n_mis++; $display("FAIL ar_resume_instr got %h exp %h", instr_d_o, 32'hF84000A0); end n_cmp++;
    if (pc_d_o !== 64'h0) begin n_mis++; $display("FAIL ar_resume_pc_d got %h exp 0", pc_d_o); end n_cmp++;
    if (valid_d_o !== 1'b1) begin n_mis++; $display("FAIL ar_resume_valid got %b exp 1", valid_d_o); end n_cmp++;
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_stall();
    test_redirect();
    test_misaligned();
    test_range();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
